// File: rtl/fir_sm_fifo.sv
// Output FIFO behind the FIR stream master; counts samples and pulses done on tlast.
// Define FIR_SM_FIFO_LEN_CHK_EN to enable the tlast/data_length check (err_len).
module fir_sm_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  input  logic [31:0]            data_length,
  input  logic                   clr,
  output logic [31:0]            rx_cnt,
  output logic [31:0]            tx_cnt,
  output logic                   done,
  output logic                   err_len
);

  localparam int AW = $clog2(pDEPTH);

  logic [pDATA_WIDTH:0] mem_q [pDEPTH];
  logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
  logic [31:0]          rx_q, rx_d, tx_q, tx_d;
  logic [31:0]          rx_base, rx_inc;
  logic                 done_q, done_d, err_q, err_d;
  logic [pDATA_WIDTH:0] head;
  logic                 full, empty, push, pop, pop_last;

  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);
  assign head  = mem_q[rd_q[AW-1:0]];

  assign s_tready = !full;
  assign m_tvalid = !empty;
  assign m_tdata  = empty ? '0 : head[pDATA_WIDTH-1:0];
  assign m_tlast  = !empty && head[pDATA_WIDTH];

  assign push     = s_tvalid && !full && !clr;
  assign pop      = !empty && m_tready && !clr;
  assign pop_last = pop && head[pDATA_WIDTH];

  // A frame ends when its last beat leaves; a push on that edge is beat 1.
  assign rx_base = pop_last ? 32'd0 : rx_q;
  assign rx_inc  = rx_base + 32'd1;

`ifdef FIR_SM_FIFO_LEN_CHK_EN
  logic len_bad;
  assign len_bad = push && (s_tlast != (rx_inc == data_length));
`else
  logic unused_len;
  assign unused_len = ^data_length;
`endif

  always_comb begin
    wr_d   = wr_q + {{AW{1'b0}}, push};
    rd_d   = rd_q + {{AW{1'b0}}, pop};
    rx_d   = push ? rx_inc : rx_base;
    tx_d   = pop_last ? 32'd0 : tx_q + {31'd0, pop};
    done_d = pop_last;
`ifdef FIR_SM_FIFO_LEN_CHK_EN
    err_d  = err_q || len_bad;
`else
    err_d  = 1'b0;
`endif
    if (clr) begin
      wr_d   = '0;
      rd_d   = '0;
      rx_d   = '0;
      tx_d   = '0;
      done_d = 1'b0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      rx_q   <= '0;
      tx_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < pDEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      done_q <= done_d;
      err_q  <= err_d;
      if (push) mem_q[wr_q[AW-1:0]] <= {s_tlast, s_tdata};
    end
  end

  assign rx_cnt  = rx_q;
  assign tx_cnt  = tx_q;
  assign done    = done_q;
  assign err_len = err_q;

endmodule

// File: tb/tb_fir_sm_fifo.sv
// Scoreboard bench for fir_sm_fifo: driver queues expected beats,
// a negedge monitor pops and compares on every downstream handshake.
module tb_fir_sm_fifo;

`ifdef FIR_SM_FIFO_LEN_CHK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic [31:0] data_length = '0;
  logic        clr = 1'b0;
  logic [31:0] rx_cnt, tx_cnt;
  logic        done, err_len;

  fir_sm_fifo #(.pDATA_WIDTH(32), .pDEPTH(4)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata),
    .m_tlast(m_tlast), .m_tready(m_tready),
    .data_length(data_length), .clr(clr),
    .rx_cnt(rx_cnt), .tx_cnt(tx_cnt),
    .done(done), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  bit done_exp = 1'b0;
  logic [32:0] exp_q [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a handshake seen at negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_exp = 1'b0;
    end else begin
      if (done || done_exp) chk("done", 64'(done), 64'(done_exp));
      if (done) done_cnt++;
      done_exp = 1'b0;
      if (!clr && m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'({m_tlast, m_tdata}), 64'h1_0000_0000_0);
        end else begin
          chk("beat", 64'({m_tlast, m_tdata}), 64'(exp_q.pop_front()));
        end
        done_exp = m_tlast;
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [31:0] d, input logic l);
    int t = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    @(negedge clk);
    while (!s_tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send_timeout", 64'(t), 64'd0);
    exp_q.push_back({l, d});
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    m_tready = 1'b1;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    int d0;
    #12;
    chk("rst_s_tready", 64'(s_tready), 64'd1);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast",  64'(m_tlast),  64'd0);
    chk("rst_m_tdata",  64'(m_tdata),  64'd0);
    chk("rst_cnts",     64'({rx_cnt, tx_cnt}), 64'd0);
    chk("rst_flags",    64'({done, err_len}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic 600-sample frame
    data_length = 32'd600;
    m_tready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      send(32'hA000_0000 + 32'(i), i == 599);
      if (i == 0) begin
        chk("fwft_valid", 64'(m_tvalid), 64'd1);
        chk("fwft_data",  64'(m_tdata),  64'hA000_0000);
      end
    end
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("basic_cnts", 64'({rx_cnt, tx_cnt}), 64'd0);
    chk("basic_err",  64'(err_len), 64'd0);
    chk("basic_done_cnt", 64'(done_cnt), 64'd1);

    // Backpressure
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hB0 + 32'(i), 1'b0);
    chk("bp_full", 64'(s_tready), 64'd0);
    s_tvalid = 1'b1;
    s_tdata  = 32'hB4;
    exp_q.push_back({1'b0, 32'hB4});
    repeat (2) @(posedge clk);
    #1;
    chk("bp_hold_rdy", 64'(s_tready), 64'd0);
    chk("bp_hold_rx",  64'(rx_cnt), 64'd4);
    m_tready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rdy_rise", 64'(s_tready), 64'd1);
    chk("bp_rx_4",     64'(rx_cnt), 64'd4);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    chk("bp_rx_5", 64'(rx_cnt), 64'd5);
    drain();
    chk("bp_tx", 64'(tx_cnt), 64'd5);
    pulse_clr();

    // Concurrent push and pop at occupancy 2
    m_tready = 1'b0;
    send(32'hC1, 1'b0);
    send(32'hC2, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 32'hC3;
    exp_q.push_back({1'b0, 32'hC3});
    m_tready = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    chk("cc_rx", 64'(rx_cnt), 64'd3);
    chk("cc_tx", 64'(tx_cnt), 64'd1);
    chk("cc_occ", 64'(rx_cnt - tx_cnt), 64'd2);
    chk("cc_valid", 64'({m_tvalid, s_tready}), 64'd3);
    drain();
    pulse_clr();

    // tlast before data_length
    data_length = 32'd10;
    m_tready = 1'b1;
    for (int i = 1; i <= 8; i++) send(32'hD0 + 32'(i), i == 8);
    chk("len_err", 64'(err_len), 64'(LEN_CHK));
    m_tready = 1'b0;
    send(32'hD9, 1'b0);
    chk("len_err_held", 64'(err_len), 64'(LEN_CHK));
    pulse_clr();
    chk("clr_err", 64'(err_len), 64'd0);
    chk("clr_cnts", 64'({rx_cnt, tx_cnt}), 64'd0);
    chk("clr_empty", 64'({m_tvalid, s_tready}), 64'd1);

    // Missing tlast
    data_length = 32'd3;
    m_tready = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) send(32'hE0 + 32'(i), 1'b0);
    chk("miss_err", 64'(err_len), 64'(LEN_CHK));
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("miss_no_done", 64'(done_cnt), 64'(d0));
    chk("miss_err_held", 64'(err_len), 64'(LEN_CHK));
    pulse_clr();

    // Asynchronous reset with 3 entries stored
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'hF0 + 32'(i), 1'b0);
    chk("ar_pre", 64'(rx_cnt), 64'd3);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("ar_valid", 64'(m_tvalid), 64'd0);
    chk("ar_ready", 64'(s_tready), 64'd1);
    chk("ar_cnts",  64'({rx_cnt, tx_cnt}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_tready = 1'b1;
    send(32'h1234_5678, 1'b0);
    drain();
    chk("ar_after", 64'(tx_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_sm_fifo.md
# fir_sm_fifo

Output-side buffer that sits directly downstream of the `fir` core's AXI-Stream master (`sm_*`). It absorbs FIR output samples into a small FIFO and re-presents them on a downstream AXI-Stream master. It counts samples and checks that `tlast` arrives exactly at the programmed data length. It also raises a one-cycle `done` pulse when the final sample leaves, so the system can release `sm_tready` backpressure decoupling without stalling the FIR pipeline.

## Interface
- `pDATA_WIDTH`, 32, stream data width
- `pDEPTH`, 4, FIFO depth in entries; power of two, ≥2
- `axis_clk`  in  1  clock; all logic on rising edge
- `axis_rst_n`  in  1  asynchronous, active-low reset
- `s_tvalid`  in  1  from FIR `sm_tvalid`
- `s_tdata`  in  pDATA_WIDTH  from FIR `sm_tdata`
- `s_tlast`  in  1  from FIR `sm_tlast`
- `s_tready`  out  1  to FIR `sm_tready`
- `m_tvalid`  out  1  downstream valid
- `m_tdata`  out  pDATA_WIDTH  downstream data
- `m_tlast`  out  1  downstream last
- `m_tready`  in  1  downstream ready
- `data_length`  in  32  expected sample count per frame (same value programmed at FIR offset 0x10); sampled while idle
- `clr`  in  1  synchronous clear of counters, FIFO and error
- `rx_cnt`  out  32  samples accepted on `s_*` this frame
- `tx_cnt`  out  32  samples delivered on `m_*` this frame
- `done`  out  1  one-cycle pulse on the delivery of the `m_tlast` beat
- `err_len`  out  1  sticky length/tlast mismatch flag

## Operation
- Storage: `pDEPTH` entries of {tlast, tdata}, with write and read pointers of log2(pDEPTH)+1 bits. Full when pointers differ only in the MSB; empty when they are equal.
- Push: `s_tvalid && s_tready`. `s_tready = !full` (combinational from pointers). Push writes the entry and increments `wr_ptr` and `rx_cnt`.
- Pop: `m_tvalid && m_tready`. `m_tvalid = !empty`. `m_tdata`/`m_tlast` = entry at `rd_ptr`. Pop increments `rd_ptr` and `tx_cnt`.
- Simultaneous push and pop: both occur, occupancy unchanged. When full, `s_tready` = 0, so no push occurs even if a pop occurs that same cycle. When empty, no pop.
- Counters are 32-bit and wrap modulo 2^32 with no saturation.
- `done`: registered, high for exactly one cycle after a pop whose `m_tlast` = 1. On that same edge, `rx_cnt` and `tx_cnt` reset to 0, ready for the next frame. Pushes accepted on that edge count from 1.
- Length check (see Configuration): evaluated on each push, using `rx_cnt+1`.
- `clr` = 1: on the next edge, pointers, counters, `done` and `err_len` all go to 0, and any FIFO contents are discarded. `clr` has priority over a simultaneous push or pop; the beats offered that cycle are not accepted.
- Reset mid-frame: asynchronous. Stored data is lost and outputs return to their reset values immediately.

## Timing
- Reset values: `s_tready`=1, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `rx_cnt`=0, `tx_cnt`=0, `done`=0, `err_len`=0.
- Latency: a sample pushed at edge N is visible with `m_tvalid`=1 after edge N (first-word fall-through).
- Throughput: 1 beat/cycle sustained when `m_tready` is held high.
- AXI-Stream rules: `m_tvalid` never drops without a pop. `m_tdata`/`m_tlast` are stable while `m_tvalid && !m_tready`.
- `s_tready` drops in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from full.

## Configuration
- `FIR_SM_FIFO_LEN_CHK_EN` defined: `err_len` is set, and held until `clr` or reset, when either:
  - a push has `s_tlast`=1 and `rx_cnt+1 != data_length`, or
  - a push has `rx_cnt+1 == data_length` and `s_tlast`=0.
- Not defined: no length comparison logic. `err_len` is tied to 0 and `data_length` is unused. `done` still follows `m_tlast`.

## Test plan
- Basic flow: reset, `data_length`=600, `m_tready`=1, push 600 samples with `tlast` on #599. Required: 600 beats out in order, 1-cycle latency; `done` pulses once after beat 599; counters return to 0; `err_len`=0.
- Backpressure: `m_tready`=0, push 5 beats. Required: 4 accepted and `s_tready`=0 after the 4th. Then set `m_tready`=1 with `s_tvalid` held: the 5th beat is accepted the cycle after the first pop; data order is preserved.
- Concurrency: FIFO at 2 entries, push and pop on the same edge. Required: occupancy stays 2, `rx_cnt` and `tx_cnt` each increment by 1.
- Length error (macro on): `data_length`=10, `tlast` on beat 8. Required: `err_len`=1 after that edge and held. `clr` pulse → `err_len`=0, counters=0, FIFO empty.
- Missing tlast (macro on): `data_length`=3, 3 beats, all with `tlast`=0. Required: `err_len`=1 after beat 3 and `done` never pulses. With the macro off, the same stimulus leaves `err_len`=0.
- Async reset mid-frame: assert `axis_rst_n`=0 with 3 entries stored. Required: `m_tvalid`=0, `s_tready`=1 and counters=0 immediately, without waiting for a clock edge.
